// File: rtl/controladora_lamp_if.sv
// Board-facing signal bundle of the lamp controller: raw button/IR inputs
// and the mode indicator / lamp drive outputs.
interface controladora_lamp_if;
    logic push_button;
    logic infravermelho;
    logic led;
    logic saida;

    modport master (
        output push_button,
        output infravermelho,
        input  led,
        input  saida
    );

    modport slave (
        input  push_button,
        input  infravermelho,
        output led,
        output saida
    );
endinterface

// File: rtl/controladora_lamp.sv
// Presence-driven lamp controller: IR sensor lights the lamp in AUTO mode with a
// no-presence shutdown timer; a long button press toggles MANUAL mode (short presses toggle the lamp).
module controladora_lamp #(
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5300,
    parameter int AUTO_SHUTDOWN_T   = 30000
) (
    input  logic               clk,
    input  logic               rst,
    controladora_lamp_if.slave lamp_if
);

    localparam int DB_W  = $clog2(DEBOUNCE_P + 1);
    localparam int TMR_W = $clog2(AUTO_SHUTDOWN_T + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_P - 1);
    localparam logic [DB_W-1:0]  DB_ONE      = DB_W'(1);
    localparam logic [15:0]      LONG_THRESH = 16'(SWITCH_MODE_MIN_T - DEBOUNCE_P);
    localparam logic [15:0]      LONG_LAST   = 16'(SWITCH_MODE_MIN_T - DEBOUNCE_P - 1);
    localparam logic [15:0]      HOLD_ONE    = 16'd1;
    localparam logic [15:0]      HOLD_MAX    = 16'hFFFF;
    localparam logic [TMR_W-1:0] TMR_LOAD    = TMR_W'(AUTO_SHUTDOWN_T);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

    typedef enum logic [1:0] {
        ST_AUTO_OFF = 2'd0,
        ST_AUTO_ON  = 2'd1,
        ST_MANUAL   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers: bit 0 = button, bit 1 = IR
    // ------------------------------------------------------------------
    logic [1:0] raw_in;
    logic [1:0] sync_in;

    assign raw_in = {lamp_if.infravermelho, lamp_if.push_button};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [1:0] meta_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    meta_reg <= '0;
                end else begin
                    meta_reg <= {meta_reg[0], raw_in[gi]};
                end
            end

            assign sync_in[gi] = meta_reg[1];
        end
    endgenerate

    logic btn_sync;
    logic ir_sync;

    assign btn_sync = sync_in[0];
    assign ir_sync  = sync_in[1];

    // ------------------------------------------------------------------
    // Button debouncer and press-length timer
    // ------------------------------------------------------------------
    logic            btn_prev_reg;
    logic [DB_W-1:0] db_cnt_reg, db_cnt_next;
    logic            btn_db_reg, btn_db_next;
    logic            btn_db_d_reg;
    logic [15:0]     hold_cnt_reg, hold_cnt_next;

    always_comb begin
        db_cnt_next = db_cnt_reg;
        btn_db_next = btn_db_reg;
        // Any edge on the synchronized level, or agreement with the accepted level, restarts the count
        if ((btn_sync != btn_prev_reg) || (btn_sync == btn_db_reg)) begin
            db_cnt_next = '0;
        end else if (db_cnt_reg == DB_LAST) begin
            btn_db_next = btn_sync;
            db_cnt_next = '0;
        end else begin
            db_cnt_next = db_cnt_reg + DB_ONE;
        end
    end

    always_comb begin
        hold_cnt_next = '0;
        if (btn_db_reg) begin
            hold_cnt_next = (hold_cnt_reg == HOLD_MAX) ? hold_cnt_reg : hold_cnt_reg + HOLD_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev_reg <= 1'b0;
            db_cnt_reg   <= '0;
            btn_db_reg   <= 1'b0;
            btn_db_d_reg <= 1'b0;
            hold_cnt_reg <= '0;
        end else begin
            btn_prev_reg <= btn_sync;
            db_cnt_reg   <= db_cnt_next;
            btn_db_reg   <= btn_db_next;
            btn_db_d_reg <= btn_db_reg;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    // Long press fires exactly once: on the cycle hold_cnt steps onto the threshold.
    // Short press is judged on the cycle after the debounced release, while hold_cnt
    // still carries the final press length.
    logic long_press;
    logic short_press;

    assign long_press  = btn_db_reg && (hold_cnt_reg == LONG_LAST);
    assign short_press = btn_db_d_reg && !btn_db_reg &&
                         (hold_cnt_reg != '0) && (hold_cnt_reg < LONG_THRESH);

    // ------------------------------------------------------------------
    // Mode / lamp FSM
    // ------------------------------------------------------------------
    state_t           state_reg, state_next;
    logic             saida_reg, saida_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic             led_reg;

    always_comb begin
        state_next = state_reg;
        saida_next = saida_reg;
        timer_next = timer_reg;
        unique case (state_reg)
            ST_AUTO_OFF: begin
                if (long_press) begin
                    state_next = ST_MANUAL;
                    timer_next = '0;
                end else if (ir_sync) begin
                    state_next = ST_AUTO_ON;
                    saida_next = 1'b1;
                    timer_next = TMR_LOAD;
                end
            end
            ST_AUTO_ON: begin
                // Mode change takes priority over a coincident IR event
                if (long_press) begin
                    state_next = ST_MANUAL;
                    timer_next = '0;
                end else if (ir_sync) begin
                    timer_next = TMR_LOAD;
                end else if (timer_reg <= TMR_ONE) begin
                    state_next = ST_AUTO_OFF;
                    saida_next = 1'b0;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg - TMR_ONE;
                end
            end
            ST_MANUAL: begin
                if (long_press) begin
                    state_next = ST_AUTO_OFF;
                    saida_next = 1'b0;
                    timer_next = '0;
                end else if (short_press) begin
                    saida_next = !saida_reg;
                end
            end
            default: begin
                state_next = ST_AUTO_OFF;
                saida_next = 1'b0;
                timer_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_AUTO_OFF;
            saida_reg <= 1'b0;
            timer_reg <= '0;
            led_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            saida_reg <= saida_next;
            timer_reg <= timer_next;
            led_reg   <= (state_reg == ST_MANUAL);
        end
    end

    assign lamp_if.led   = led_reg;
    assign lamp_if.saida = saida_reg;

endmodule

// File: tb/tb_controladora_lamp.sv
// Directed-vector bench for the lamp controller: mode toggling, MANUAL lamp control,
// AUTO presence timing with retrigger, debouncing and asynchronous reset.
`timescale 1ns/1ps
module tb_controladora_lamp;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    controladora_lamp_if lamp_if ();

    controladora_lamp dut (
        .clk     (clk),
        .rst     (rst),
        .lamp_if (lamp_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges, then settle 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lamp_if.push_button   = 1'b0;
        lamp_if.infravermelho = 1'b0;
        #2 rst = 1'b0;
        tick(3);
        checks++;
        if (lamp_if.led !== 1'b0) begin
            errors++;
            $display("FAIL reset_led: got %b expected 0", lamp_if.led);
        end
        checks++;
        if (lamp_if.saida !== 1'b0) begin
            errors++;
            $display("FAIL reset_saida: got %b expected 0", lamp_if.saida);
        end
        rst = 1'b1;
        tick(1000);
        checks++;
        if (lamp_if.led !== 1'b0 || lamp_if.saida !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: got led=%b saida=%b expected led=0 saida=0",
                     lamp_if.led, lamp_if.saida);
        end
        $display("test_reset: led=%b saida=%b", lamp_if.led, lamp_if.saida);
    endtask

    task automatic test_long_press_to_manual();
        lamp_if.push_button = 1'b1;
        tick(5305);
        lamp_if.push_button = 1'b0;
        tick(5);
        checks++;
        if (lamp_if.led !== 1'b1) begin
            errors++;
            $display("FAIL long_press_manual_led: got %b expected 1", lamp_if.led);
        end
        checks++;
        if (lamp_if.saida !== 1'b0) begin
            errors++;
            $display("FAIL long_press_manual_saida: got %b expected 0", lamp_if.saida);
        end
        $display("test_long_press_to_manual: led=%b saida=%b", lamp_if.led, lamp_if.saida);
    endtask

    task automatic test_manual_ignores_ir();
        for (int i = 0; i < 10; i++) begin
            int width;
            int gap;
            width = int'($urandom_range(30, 1));
            gap   = int'($urandom_range(2000, 1));
            lamp_if.infravermelho = 1'b1;
            tick(width);
            lamp_if.infravermelho = 1'b0;
            tick(gap);
            checks++;
            if (lamp_if.led !== 1'b1) begin
                errors++;
                $display("FAIL manual_ir_led[%0d]: got %b expected 1", i, lamp_if.led);
            end
            checks++;
            if (lamp_if.saida !== 1'b0) begin
                errors++;
                $display("FAIL manual_ir_saida[%0d]: got %b expected 0", i, lamp_if.saida);
            end
            $display("test_manual_ignores_ir: pulse %0d width=%0d gap=%0d led=%b saida=%b",
                     i, width, gap, lamp_if.led, lamp_if.saida);
        end
    endtask

    task automatic test_manual_short_press();
        tick(400);
        lamp_if.push_button = 1'b1;
        tick(1000);
        lamp_if.push_button = 1'b0;
        tick(200);
        checks++;
        if (lamp_if.saida !== 1'b0) begin
            errors++;
            $display("FAIL short_press_early: got %b expected 0", lamp_if.saida);
        end
        tick(120);
        checks++;
        if (lamp_if.saida !== 1'b1) begin
            errors++;
            $display("FAIL short_press_toggle: got %b expected 1", lamp_if.saida);
        end
        tick(2000);
        checks++;
        if (lamp_if.saida !== 1'b1 || lamp_if.led !== 1'b1) begin
            errors++;
            $display("FAIL short_press_single: got saida=%b led=%b expected saida=1 led=1",
                     lamp_if.saida, lamp_if.led);
        end
        $display("test_manual_short_press: led=%b saida=%b", lamp_if.led, lamp_if.saida);
    endtask

    task automatic test_short_glitch_press();
        lamp_if.push_button = 1'b1;
        tick(200);
        lamp_if.push_button = 1'b0;
        tick(400);
        checks++;
        if (lamp_if.saida !== 1'b1 || lamp_if.led !== 1'b1) begin
            errors++;
            $display("FAIL press_200: got saida=%b led=%b expected saida=1 led=1",
                     lamp_if.saida, lamp_if.led);
        end
        $display("test_short_glitch_press: led=%b saida=%b", lamp_if.led, lamp_if.saida);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 25; i++) begin
            lamp_if.push_button = (i % 2 == 0);
            tick(10);
        end
        lamp_if.push_button = 1'b0;
        tick(400);
        checks++;
        if (lamp_if.saida !== 1'b1 || lamp_if.led !== 1'b1) begin
            errors++;
            $display("FAIL bounce: got saida=%b led=%b expected saida=1 led=1",
                     lamp_if.saida, lamp_if.led);
        end
        $display("test_bounce: led=%b saida=%b", lamp_if.led, lamp_if.saida);
    endtask

    task automatic test_long_press_to_auto();
        lamp_if.push_button = 1'b1;
        tick(5305);
        lamp_if.push_button = 1'b0;
        tick(5);
        checks++;
        if (lamp_if.led !== 1'b0) begin
            errors++;
            $display("FAIL long_press_auto_led: got %b expected 0", lamp_if.led);
        end
        checks++;
        if (lamp_if.saida !== 1'b0) begin
            errors++;
            $display("FAIL long_press_auto_saida: got %b expected 0", lamp_if.saida);
        end
        tick(400);
        checks++;
        if (lamp_if.led !== 1'b0 || lamp_if.saida !== 1'b0) begin
            errors++;
            $display("FAIL long_release_auto: got led=%b saida=%b expected led=0 saida=0",
                     lamp_if.led, lamp_if.saida);
        end
        $display("test_long_press_to_auto: led=%b saida=%b", lamp_if.led, lamp_if.saida);
    endtask

    task automatic test_auto_retrigger();
        lamp_if.infravermelho = 1'b1;
        tick(3);
        checks++;
        if (lamp_if.saida !== 1'b1) begin
            errors++;
            $display("FAIL auto_light: got %b expected 1", lamp_if.saida);
        end
        tick(2);
        lamp_if.infravermelho = 1'b0;
        tick(19995);
        checks++;
        if (lamp_if.saida !== 1'b1) begin
            errors++;
            $display("FAIL auto_mid_count: got %b expected 1", lamp_if.saida);
        end
        lamp_if.infravermelho = 1'b1;
        tick(5);
        lamp_if.infravermelho = 1'b0;
        tick(10015);
        checks++;
        if (lamp_if.saida !== 1'b1) begin
            errors++;
            $display("FAIL auto_retrigger: got %b expected 1", lamp_if.saida);
        end
        tick(19980);
        checks++;
        if (lamp_if.saida !== 1'b1) begin
            errors++;
            $display("FAIL auto_before_shutdown: got %b expected 1", lamp_if.saida);
        end
        tick(15);
        checks++;
        if (lamp_if.saida !== 1'b0) begin
            errors++;
            $display("FAIL auto_shutdown: got %b expected 0", lamp_if.saida);
        end
        checks++;
        if (lamp_if.led !== 1'b0) begin
            errors++;
            $display("FAIL auto_led: got %b expected 0", lamp_if.led);
        end
        $display("test_auto_retrigger: led=%b saida=%b", lamp_if.led, lamp_if.saida);
    endtask

    task automatic test_async_reset();
        lamp_if.infravermelho = 1'b1;
        tick(5);
        lamp_if.infravermelho = 1'b0;
        tick(1000);
        checks++;
        if (lamp_if.saida !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_saida: got %b expected 1", lamp_if.saida);
        end
        #3 rst = 1'b0;
        #1;
        checks++;
        if (lamp_if.saida !== 1'b0 || lamp_if.led !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got saida=%b led=%b expected saida=0 led=0",
                     lamp_if.saida, lamp_if.led);
        end
        tick(3);
        rst = 1'b1;
        tick(2);
        lamp_if.infravermelho = 1'b1;
        tick(3);
        checks++;
        if (lamp_if.saida !== 1'b1) begin
            errors++;
            $display("FAIL relight_after_reset: got %b expected 1", lamp_if.saida);
        end
        lamp_if.infravermelho = 1'b0;
        tick(2);
        $display("test_async_reset: led=%b saida=%b", lamp_if.led, lamp_if.saida);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_long_press_to_manual();
        test_manual_ignores_ir();
        test_manual_short_press();
        test_short_glitch_press();
        test_bounce();
        test_long_press_to_auto();
        test_auto_retrigger();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
